// File: rtl/pixel_xy_tracker_if.sv
// Bus between the OLED driver / drawing logic and pixel_xy_tracker:
// index, transform mode and window bounds in; transformed coordinates and status out.
interface pixel_xy_tracker_if #(
    parameter int IDX_W = 13,
    parameter int X_W   = 7,
    parameter int Y_W   = 7
);
    logic [IDX_W-1:0] pixel_index;
    logic [1:0]       mode;
    logic [X_W-1:0]   win_x0;
    logic [X_W-1:0]   win_x1;
    logic [Y_W-1:0]   win_y0;
    logic [Y_W-1:0]   win_y1;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic             valid;
    logic             busy;
    logic             frame_start;
    logic             in_window;

    modport master (
        output pixel_index, mode, win_x0, win_x1, win_y0, win_y1,
        input  x, y, valid, busy, frame_start, in_window
    );

    modport slave (
        input  pixel_index, mode, win_x0, win_x1, win_y0, win_y1,
        output x, y, valid, busy, frame_start, in_window
    );
endinterface

// File: rtl/pixel_xy_tracker.sv
// Pixel index to (x,y) converter: incremental tracking for sequential indices,
// restoring shift-subtract divider for jumps, plus mirror/rotate and window flag.
module pixel_xy_tracker #(
    parameter int WIDTH  = 96,
    parameter int HEIGHT = 64,
    parameter int IDX_W  = 13,
    parameter int X_W    = 7,
    parameter int Y_W    = 7
) (
    input  logic               clk,
    input  logic               reset,
    pixel_xy_tracker_if.slave  bus
);
    localparam int REM_W = IDX_W + Y_W;
    localparam int CNT_W = (Y_W > 1) ? $clog2(Y_W + 1) : 1;
    localparam logic [IDX_W:0]   PIX_N     = (IDX_W+1)'(WIDTH * HEIGHT);
    localparam logic [REM_W-1:0] WIDTH_EXT = REM_W'(WIDTH);
    localparam logic [X_W-1:0]   X_LAST    = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(HEIGHT - 1);

    typedef enum logic [0:0] {
        ST_TRACK = 1'b0,
        ST_DIV   = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [X_W-1:0]     x_raw_q, x_raw_d;
    logic [Y_W-1:0]     y_raw_q, y_raw_d;
    logic               lost_q, lost_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [Y_W-1:0]     quo_q, quo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               frame_start_q, frame_start_d;
    logic               in_window_q, in_window_d;

    logic [REM_W-1:0]   divisor_s;
    logic [REM_W-1:0]   rem_next_s;
    logic               qbit_s;

    // Next-state: tracking rules, divider steps and output transform
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        x_raw_d       = x_raw_q;
        y_raw_d       = y_raw_q;
        lost_d        = lost_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        cnt_d         = cnt_q;
        valid_d       = valid_q;
        busy_d        = busy_q;
        frame_start_d = 1'b0;
        divisor_s     = WIDTH_EXT << cnt_q;
        rem_next_s    = rem_q;
        qbit_s        = 1'b0;

        case (state_q)
            ST_TRACK: begin
                if ({1'b0, bus.pixel_index} >= PIX_N) begin
                    lost_d  = 1'b1;
                    valid_d = 1'b0;
                    idx_d   = bus.pixel_index;
                end else if ((bus.pixel_index == idx_q) && !lost_q) begin
                    idx_d = idx_q;
                end else if (bus.pixel_index == {IDX_W{1'b0}}) begin
                    x_raw_d       = {X_W{1'b0}};
                    y_raw_d       = {Y_W{1'b0}};
                    idx_d         = {IDX_W{1'b0}};
                    lost_d        = 1'b0;
                    valid_d       = 1'b1;
                    frame_start_d = (idx_q != {IDX_W{1'b0}});
                end else if (({1'b0, bus.pixel_index} == ({1'b0, idx_q} + {{IDX_W{1'b0}}, 1'b1}))
                             && !lost_q) begin
                    if (x_raw_q == X_LAST) begin
                        x_raw_d = {X_W{1'b0}};
                        y_raw_d = y_raw_q + {{(Y_W-1){1'b0}}, 1'b1};
                    end else begin
                        x_raw_d = x_raw_q + {{(X_W-1){1'b0}}, 1'b1};
                        y_raw_d = y_raw_q;
                    end
                    idx_d   = bus.pixel_index;
                    valid_d = 1'b1;
                end else begin
                    rem_d   = REM_W'(bus.pixel_index);
                    quo_d   = {Y_W{1'b0}};
                    cnt_d   = CNT_W'(Y_W - 1);
                    idx_d   = bus.pixel_index;
                    state_d = ST_DIV;
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_DIV: begin
                // One quotient bit per edge, most significant first
                if (rem_q >= divisor_s) begin
                    rem_next_s = rem_q - divisor_s;
                    qbit_s     = 1'b1;
                end else begin
                    rem_next_s = rem_q;
                    qbit_s     = 1'b0;
                end
                rem_d = rem_next_s;
                quo_d = {quo_q[Y_W-2:0], qbit_s};
                if (cnt_q == {CNT_W{1'b0}}) begin
                    x_raw_d = X_W'(rem_next_s);
                    y_raw_d = quo_d;
                    lost_d  = 1'b0;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_TRACK;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_TRACK;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        if (bus.mode[0]) begin
            x_d = X_LAST - x_raw_d;
        end else begin
            x_d = x_raw_d;
        end
        if (bus.mode[1]) begin
            y_d = Y_LAST - y_raw_d;
        end else begin
            y_d = y_raw_d;
        end

        // An inverted window can never match because both bounds checks cannot hold
        in_window_d = valid_d
                    && (bus.win_x0 <= bus.win_x1) && (bus.win_y0 <= bus.win_y1)
                    && (x_d >= bus.win_x0) && (x_d <= bus.win_x1)
                    && (y_d >= bus.win_y0) && (y_d <= bus.win_y1);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_TRACK;
            idx_q         <= {IDX_W{1'b0}};
            x_raw_q       <= {X_W{1'b0}};
            y_raw_q       <= {Y_W{1'b0}};
            lost_q        <= 1'b0;
            rem_q         <= {REM_W{1'b0}};
            quo_q         <= {Y_W{1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
            x_q           <= {X_W{1'b0}};
            y_q           <= {Y_W{1'b0}};
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            frame_start_q <= 1'b0;
            in_window_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            x_raw_q       <= x_raw_d;
            y_raw_q       <= y_raw_d;
            lost_q        <= lost_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            cnt_q         <= cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            valid_q       <= valid_d;
            busy_q        <= busy_d;
            frame_start_q <= frame_start_d;
            in_window_q   <= in_window_d;
        end
    end

    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.valid       = valid_q;
    assign bus.busy        = busy_q;
    assign bus.frame_start = frame_start_q;
    assign bus.in_window   = in_window_q;
endmodule

// File: tb/tb_pixel_xy_tracker.sv
// Bench for pixel_xy_tracker: an arithmetic (div/mod) reference model checked every
// cycle, plus directed scenarios with hand-computed literal coordinates.
module tb_pixel_xy_tracker;
    localparam int WIDTH  = 96;
    localparam int HEIGHT = 64;
    localparam int IDX_W  = 13;
    localparam int X_W    = 7;
    localparam int Y_W    = 7;
    localparam int PIX_N  = WIDTH * HEIGHT;

    logic clk;
    logic reset;
    pixel_xy_tracker_if #(.IDX_W(IDX_W), .X_W(X_W), .Y_W(Y_W)) bus ();

    pixel_xy_tracker #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .IDX_W(IDX_W), .X_W(X_W), .Y_W(Y_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference state: resolved index, raw coordinates, flags, pending divide time
    int m_idx, m_xr, m_yr, m_div_left, m_div_p;
    bit m_lost, m_valid, m_busy, m_fs;
    int e_x, e_y;
    bit e_win;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int p;
        p = int'(bus.pixel_index);
        m_fs = 1'b0;
        if (reset) begin
            m_idx = 0; m_xr = 0; m_yr = 0; m_lost = 0;
            m_valid = 0; m_busy = 0; m_div_left = 0;
        end else if (m_div_left > 0) begin
            m_div_left--;
            if (m_div_left == 0) begin
                m_xr = m_div_p % WIDTH;
                m_yr = m_div_p / WIDTH;
                m_idx = m_div_p; m_lost = 0; m_valid = 1; m_busy = 0;
            end
        end else if (p >= PIX_N) begin
            m_lost = 1; m_valid = 0; m_idx = p;
        end else if (p == m_idx && !m_lost) begin
            m_idx = m_idx;
        end else if (p == 0) begin
            m_fs = (m_idx != 0);
            m_xr = 0; m_yr = 0; m_idx = 0; m_lost = 0; m_valid = 1;
        end else if (p == m_idx + 1 && !m_lost) begin
            m_xr = p % WIDTH; m_yr = p / WIDTH; m_idx = p; m_valid = 1;
        end else begin
            m_div_left = Y_W; m_div_p = p; m_idx = p; m_valid = 0; m_busy = 1;
        end
        e_x = bus.mode[0] ? (WIDTH - 1 - m_xr) : m_xr;
        e_y = bus.mode[1] ? (HEIGHT - 1 - m_yr) : m_yr;
        e_win = m_valid
             && e_x >= int'(bus.win_x0) && e_x <= int'(bus.win_x1)
             && e_y >= int'(bus.win_y0) && e_y <= int'(bus.win_y1);
    endtask

    // Every-cycle comparison against the reference model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("x",           int'(bus.x),           e_x);
            chk("y",           int'(bus.y),           e_y);
            chk("valid",       int'(bus.valid),       int'(m_valid));
            chk("busy",        int'(bus.busy),        int'(m_busy));
            chk("frame_start", int'(bus.frame_start), int'(m_fs));
            chk("in_window",   int'(bus.in_window),   int'(e_win));
        end
    end

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_div();
        for (int i = 0; i < 20 && bus.busy; i++) step();
        chk("div_done", int'(bus.busy), 0);
    endtask

    task automatic lit_xy(input string name, input int ex, input int ey);
        chk({name, "_x"}, int'(bus.x), ex);
        chk({name, "_y"}, int'(bus.y), ey);
    endtask

    int fs_count;
    int fs_at;
    int busy_cycles;

    initial begin
        reset = 1'b1;
        bus.pixel_index = '0;
        bus.mode = 2'b00;
        bus.win_x0 = 7'd0;  bus.win_x1 = 7'd95;
        bus.win_y0 = 7'd0;  bus.win_y1 = 7'd63;
        step();
        chk_en = 1'b1;
        step();
        lit_xy("reset", 0, 0);
        chk("reset_valid", int'(bus.valid), 0);
        chk("reset_busy",  int'(bus.busy), 0);
        reset = 1'b0;

        // Full-frame sweep with frame wrap
        fs_count = 0; fs_at = -1;
        for (int p = 0; p <= PIX_N; p++) begin
            bus.pixel_index = IDX_W'(p % PIX_N);
            step();
            if (bus.frame_start) begin
                fs_count++;
                fs_at = p;
            end
            if (p == 95)    lit_xy("p95", 95, 0);
            if (p == 96)    lit_xy("p96", 0, 1);
            if (p == 6143)  lit_xy("p6143", 95, 63);
            if (p == PIX_N) lit_xy("wrap", 0, 0);
        end
        chk("fs_count", fs_count, 1);
        chk("fs_at", fs_at, PIX_N);

        // Jump resolved by divider: 5000 = 52*96 + 8
        bus.pixel_index = 13'd10;
        step();
        wait_div();
        lit_xy("p10", 10, 0);
        bus.pixel_index = 13'd5000;
        step();
        busy_cycles = 0;
        while (bus.busy && busy_cycles < 20) begin
            busy_cycles++;
            step();
        end
        chk("busy_cycles", busy_cycles, 7);
        lit_xy("p5000", 8, 52);
        chk("p5000_valid", int'(bus.valid), 1);

        // Mirror / rotate modes
        bus.mode = 2'b11; bus.pixel_index = 13'd0;
        step();
        lit_xy("rot180", 95, 63);
        chk("rot180_fs", int'(bus.frame_start), 1);
        bus.mode = 2'b01; bus.pixel_index = 13'd97;
        step();
        wait_div();
        lit_xy("mirx", 94, 1);
        bus.mode = 2'b10;
        step();
        lit_xy("miry", 1, 62);

        // Out-of-range index, recovery, and reset during a divide
        bus.mode = 2'b00;
        step();
        bus.pixel_index = 13'd7000;
        step();
        lit_xy("lost_hold", 1, 1);
        chk("lost_valid", int'(bus.valid), 0);
        bus.pixel_index = 13'd200;
        step();
        wait_div();
        lit_xy("p200", 8, 2);
        bus.pixel_index = 13'd7000;
        step();
        bus.pixel_index = 13'd200;
        step();
        step();
        step();
        reset = 1'b1;
        bus.pixel_index = 13'd0;
        step();
        lit_xy("midreset", 0, 0);
        chk("midreset_busy",  int'(bus.busy), 0);
        chk("midreset_valid", int'(bus.valid), 0);
        reset = 1'b0;
        step();

        // Window flag, including an inverted window
        bus.win_x0 = 7'd10; bus.win_x1 = 7'd20;
        bus.win_y0 = 7'd5;  bus.win_y1 = 7'd6;
        bus.pixel_index = 13'd586;
        step();
        wait_div();
        lit_xy("p586", 10, 6);
        chk("win586", int'(bus.in_window), 1);
        bus.pixel_index = 13'd587;
        step();
        chk("win587", int'(bus.in_window), 1);
        bus.pixel_index = 13'd491;
        step();
        wait_div();
        lit_xy("p491", 11, 5);
        chk("win491", int'(bus.in_window), 1);
        bus.win_x0 = 7'd30;
        step();
        chk("win_inv491", int'(bus.in_window), 0);
        bus.pixel_index = 13'd586;
        step();
        wait_div();
        chk("win_inv586", int'(bus.in_window), 0);
        step();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
